// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   DM_DEPTH : default memory depth in 32-bit words
//   mem_op_e : memory operation codes; store codes are never valid load ops
package dm_responder_pkg;

  localparam int DM_DEPTH = 4096;
  localparam int DATA_W   = 32;

  typedef enum logic [2:0] {
    MEM_SW  = 3'd0,
    MEM_SH  = 3'd1,
    MEM_SB  = 3'd2,
    MEM_LW  = 3'd3,
    MEM_LH  = 3'd4,
    MEM_LHU = 3'd5,
    MEM_LB  = 3'd6,
    MEM_LBU = 3'd7
  } mem_op_e;

endpackage

// File: rtl/dm_responder_if.sv
// Store/load bus between the M stage (master) and the data memory (slave).
//   m_data_addr   : byte address of this cycle's store and/or load
//   m_data_wdata  : lane-aligned store data
//   m_data_byteen : per-lane store enable, 0 = no store
//   ld_en / ld_op : load request and load type
//   rdata         : extended load result (held while rvalid=0)
//   rvalid        : one-cycle pulse, one cycle after ld_en
//   err           : one-cycle fault pulse
interface dm_responder_if;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic        ld_en;
  logic [2:0]  ld_op;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;

  modport master (
    output m_data_addr, m_data_wdata, m_data_byteen, ld_en, ld_op,
    input  rdata, rvalid, err
  );

  modport slave (
    input  m_data_addr, m_data_wdata, m_data_byteen, ld_en, ld_op,
    output rdata, rvalid, err
  );
endinterface

// File: rtl/dm_responder_load_ext.sv
// Load lane extraction and sign/zero extension.
//   word       : full 32-bit memory word
//   off        : byte offset within the word (addr[1:0])
//   op         : load type
//   value      : extended result (0 on illegal op)
//   misaligned : LW with off!=0 or LH/LHU with odd off
//   illegal    : op is not a load encoding
module dm_responder_load_ext
  import dm_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  op,
  output logic [31:0] value,
  output logic        misaligned,
  output logic        illegal
);

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return sgn ? {{16{h[15]}}, h} : {16'd0, h};
  endfunction

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return sgn ? {{24{b[7]}}, b} : {24'd0, b};
  endfunction

  logic [15:0] half;
  logic [7:0]  lane;

  always_comb begin
    half = off[1] ? word[31:16] : word[15:0];
    case (off)
      2'd0:    lane = word[7:0];
      2'd1:    lane = word[15:8];
      2'd2:    lane = word[23:16];
      default: lane = word[31:24];
    endcase
  end

  always_comb begin
    value      = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (op)
      MEM_LW:  begin misaligned = (off != 2'b00); value = word;             end
      MEM_LH:  begin misaligned = off[0];         value = ext16(half, 1'b1); end
      MEM_LHU: begin misaligned = off[0];         value = ext16(half, 1'b0); end
      MEM_LB:  begin                              value = ext8(lane, 1'b1);  end
      MEM_LBU: begin                              value = ext8(lane, 1'b0);  end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: byte-masked stores and one-cycle-latency loads with
// lane extraction/extension, so W stage gets a ready-to-write GPR value.
//   clk   : system clock
//   reset : synchronous active-high reset (clears memory and outputs)
//   bus   : dm_responder_if slave (store/load request, rdata/rvalid/err)
// Loads are read-first against a same-cycle store to the same word.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int DEPTH  = DM_DEPTH,
  parameter int ADDR_W = 12
) (
  input  logic          clk,
  input  logic          reset,
  dm_responder_if.slave bus
);

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              in_range;

  assign idx      = bus.m_data_addr[ADDR_W+1:2];
  assign in_range = (bus.m_data_addr < 32'(DEPTH * 4));

  // Stage p0: request cycle -- memory write (reset clears the whole array)
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.m_data_byteen[b]) mem[idx][8*b +: 8] <= bus.m_data_wdata[8*b +: 8];
      end
    end
  end

  // Stage p1: captured load context; only refreshed on ld_en so rdata holds
  logic        vld_p1;
  logic        st_err_p1;
  logic        range_ok_p1;
  logic [31:0] word_p1;
  logic [1:0]  off_p1;
  logic [2:0]  op_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      st_err_p1   <= 1'b0;
      range_ok_p1 <= 1'b1;
      word_p1     <= '0;
      off_p1      <= '0;
      op_p1       <= MEM_LW;
    end else begin
      vld_p1    <= bus.ld_en;
      st_err_p1 <= (bus.m_data_byteen != 4'd0) && !in_range;
      if (bus.ld_en) begin
        word_p1     <= mem[idx];
        off_p1      <= bus.m_data_addr[1:0];
        op_p1       <= bus.ld_op;
        range_ok_p1 <= in_range;
      end
    end
  end

  logic [31:0] ext_value;
  logic        misaligned;
  logic        illegal;
  logic        ld_fault;

  dm_responder_load_ext u_load_ext (
    .word       (word_p1),
    .off        (off_p1),
    .op         (op_p1),
    .value      (ext_value),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  assign ld_fault   = misaligned || illegal || !range_ok_p1;
  assign bus.rdata  = ld_fault ? 32'd0 : ext_value;
  assign bus.rvalid = vld_p1;
  assign bus.err    = (vld_p1 && ld_fault) || st_err_p1;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed steps followed by random traffic, each
// cycle compared against a byte-array reference model.
module tb_dm_responder;
  import dm_responder_pkg::*;

  localparam int DEPTH  = 4096;
  localparam int NBYTES = DEPTH * 4;

  logic clk = 1'b0;
  logic reset;

  dm_responder_if bus ();

  dm_responder #(.DEPTH(DEPTH), .ADDR_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  bit [7:0]    bytes [NBYTES];
  logic [31:0] exp_rdata;
  logic        exp_rvalid;
  logic        exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory, loads evaluated before the store lands.
  task automatic model_step(input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be, input logic le, input logic [2:0] op);
    int          sz;
    bit          sgn;
    bit          ld_fault;
    bit          st_fault;
    logic [31:0] v;
    logic [31:0] base;
    st_fault = (be != 4'd0) && (a >= 32'(NBYTES));
    ld_fault = 1'b0;
    exp_rvalid = le;
    if (le) begin
      sz = 0; sgn = 1'b0;
      case (op)
        3'd3: begin sz = 4; sgn = 1'b0; end
        3'd4: begin sz = 2; sgn = 1'b1; end
        3'd5: begin sz = 2; sgn = 1'b0; end
        3'd6: begin sz = 1; sgn = 1'b1; end
        3'd7: begin sz = 1; sgn = 1'b0; end
        default: sz = 0;
      endcase
      v = 32'd0;
      if (sz == 0) ld_fault = 1'b1;
      else if (a >= 32'(NBYTES)) ld_fault = 1'b1;
      else if ((a % sz) != 0) ld_fault = 1'b1;
      if (!ld_fault) begin
        for (int k = 0; k < sz; k++) v[8*k +: 8] = bytes[a + k];
        if (sgn && v[8*sz-1]) for (int k = sz; k < 4; k++) v[8*k +: 8] = 8'hFF;
      end
      exp_rdata = v;
    end
    exp_err = ld_fault || st_fault;
    if (!st_fault) begin
      base = a & ~32'd3;
      for (int i = 0; i < 4; i++) if (be[i]) bytes[base + i] = wd[8*i +: 8];
    end
  endtask

  task automatic cycle(input string tag, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic le, input logic [2:0] op);
    bus.m_data_addr   = a;
    bus.m_data_wdata  = wd;
    bus.m_data_byteen = be;
    bus.ld_en         = le;
    bus.ld_op         = op;
    model_step(a, wd, be, le, op);
    @(posedge clk);
    #1;
    check({tag, " rvalid"}, 32'(bus.rvalid), 32'(exp_rvalid));
    check({tag, " rdata"},  bus.rdata,       exp_rdata);
    check({tag, " err"},    32'(bus.err),    32'(exp_err));
    bus.ld_en         = 1'b0;
    bus.m_data_byteen = 4'd0;
  endtask

  // Reset cycle carrying a load and a store that must both be discarded.
  task automatic do_reset(input logic [31:0] a, input logic le);
    reset             = 1'b1;
    bus.m_data_addr   = a;
    bus.m_data_wdata  = 32'hDEADBEEF;
    bus.m_data_byteen = 4'hF;
    bus.ld_en         = le;
    bus.ld_op         = MEM_LW;
    @(posedge clk);
    #1;
    reset             = 1'b0;
    bus.ld_en         = 1'b0;
    bus.m_data_byteen = 4'd0;
    foreach (bytes[i]) bytes[i] = 8'd0;
    exp_rdata = 32'd0;
    check("reset rvalid", 32'(bus.rvalid), 32'd0);
    check("reset rdata",  bus.rdata,       32'd0);
    check("reset err",    32'(bus.err),    32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  be;
    logic        le;

    do_reset(32'h0, 1'b0);
    cycle("rst_lw0", 32'h0, 32'h0, 4'h0, 1'b1, MEM_LW);
    check("plan rst_lw0", bus.rdata, 32'h00000000);

    // Byte-masked stores
    cycle("sw10",   32'h10, 32'h11223344, 4'b1111, 1'b0, MEM_LW);
    cycle("sb12",   32'h12, 32'h00AA0000, 4'b0100, 1'b0, MEM_LW);
    cycle("lw10",   32'h10, 32'h0, 4'h0, 1'b1, MEM_LW);
    check("plan lw10", bus.rdata, 32'h11AA3344);
    cycle("idle_hold", 32'h0, 32'h0, 4'h0, 1'b0, MEM_LW);

    // Extension
    cycle("sw20",   32'h20, 32'h80F07F81, 4'b1111, 1'b0, MEM_LW);
    cycle("lb20",   32'h20, 32'h0, 4'h0, 1'b1, MEM_LB);
    check("plan lb20", bus.rdata, 32'hFFFFFF81);
    cycle("lbu20",  32'h20, 32'h0, 4'h0, 1'b1, MEM_LBU);
    check("plan lbu20", bus.rdata, 32'h00000081);
    cycle("lb21",   32'h21, 32'h0, 4'h0, 1'b1, MEM_LB);
    check("plan lb21", bus.rdata, 32'h0000007F);
    cycle("lh22",   32'h22, 32'h0, 4'h0, 1'b1, MEM_LH);
    check("plan lh22", bus.rdata, 32'hFFFF80F0);
    cycle("lhu22",  32'h22, 32'h0, 4'h0, 1'b1, MEM_LHU);
    check("plan lhu22", bus.rdata, 32'h000080F0);

    // Faults
    cycle("lw21",   32'h21, 32'h0, 4'h0, 1'b1, MEM_LW);
    check("plan lw21 err", 32'(bus.err), 32'd1);
    cycle("lh23",   32'h23, 32'h0, 4'h0, 1'b1, MEM_LH);
    cycle("lw_oor", 32'(NBYTES), 32'h0, 4'h0, 1'b1, MEM_LW);
    cycle("ill_op", 32'h20, 32'h0, 4'h0, 1'b1, MEM_SW);
    cycle("sw0",    32'h0, 32'hCAFEF00D, 4'b1111, 1'b0, MEM_LW);
    cycle("sw_oor", 32'(NBYTES), 32'h12345678, 4'b1111, 1'b0, MEM_LW);
    cycle("lw0_chk", 32'h0, 32'h0, 4'h0, 1'b1, MEM_LW);
    check("plan sw_oor unchanged", bus.rdata, 32'hCAFEF00D);

    // Read-first and back-to-back loads
    cycle("sw30",   32'h30, 32'h5, 4'b1111, 1'b0, MEM_LW);
    cycle("rf30",   32'h30, 32'h9, 4'b1111, 1'b1, MEM_LW);
    check("plan read_first", bus.rdata, 32'h5);
    cycle("lw30",   32'h30, 32'h0, 4'h0, 1'b1, MEM_LW);
    check("plan after_store", bus.rdata, 32'h9);
    cycle("b2b0",   32'h10, 32'h0, 4'h0, 1'b1, MEM_LW);
    cycle("b2b1",   32'h20, 32'h0, 4'h0, 1'b1, MEM_LW);
    cycle("b2b2",   32'h30, 32'h0, 4'h0, 1'b1, MEM_LW);
    cycle("idle2",  32'h0, 32'h0, 4'h0, 1'b0, MEM_LW);

    // Reset with a load in flight, then confirm memory was cleared
    do_reset(32'h10, 1'b1);
    cycle("z10", 32'h10, 32'h0, 4'h0, 1'b1, MEM_LW);
    cycle("z20", 32'h20, 32'h0, 4'h0, 1'b1, MEM_LW);
    cycle("z30", 32'h30, 32'h0, 4'h0, 1'b1, MEM_LW);
    cycle("z00", 32'h00, 32'h0, 4'h0, 1'b1, MEM_LW);
    check("plan zero after reset", bus.rdata, 32'h0);

    // Random traffic, mostly in a small window plus the top-of-memory edge
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 15))
        0:       a = 32'(NBYTES - 4) + 32'($urandom_range(0, 7));
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, 63));
      endcase
      be = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      le = ($urandom_range(0, 9) < 7);
      cycle("rand", a, $urandom, be, le, 3'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
